// File: rtl/inst_encoder.sv
// inst_encoder: pipelined RV32I immediate encoder (inverse of the immediate generator).
// Scatters a 32-bit immediate into the bit positions of the selected format, flags values
// that the format cannot represent, and streams finished words with a sequential address.
//
// Parameters:
//   ADDR_W  width of the output word-address counter (wraps at 2^ADDR_W)
//   STRICT  1: erroneous words are dropped in S1; 0: emitted with error flags set
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   in_valid / in_ready   input handshake
//   immsel                one-hot format: 00001 I, 00010 S, 00100 B, 01000 J, 10000 U, 0 none
//   imm                   immediate value (byte offset for B/J, full value for U)
//   base                  instruction holding opcode/register/funct fields
//   addr_clr              zero the address counter (next cycle)
//   out_valid / out_ready output handshake
//   inst, out_addr        encoded instruction and its word address
//   imm_err, sel_err      immediate not representable / immsel not one-hot
//   err_count             saturating count of accepted erroneous words
module inst_encoder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned STRICT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        immsel,
  input  logic [31:0]       imm,
  input  logic [31:0]       base,
  input  logic              addr_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              imm_err,
  output logic              sel_err,
  output logic [7:0]        err_count
);

  localparam logic StrictMode = (STRICT != 0);

  // Encoded input, computed combinationally and captured into S1.
  logic [31:0] enc_inst;
  logic        enc_imm_err;
  logic        enc_sel_err;

  always_comb begin
    enc_inst    = base;
    enc_imm_err = 1'b0;
    enc_sel_err = 1'b0;
    case (immsel)
      5'b00001: begin
        enc_inst    = {imm[11:0], base[19:0]};
        enc_imm_err = imm[31:11] != {21{imm[31]}};
      end
      5'b00010: begin
        enc_inst    = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
        enc_imm_err = imm[31:11] != {21{imm[31]}};
      end
      5'b00100: begin
        enc_inst    = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
        enc_imm_err = imm[0] | (imm[31:12] != {20{imm[31]}});
      end
      5'b01000: begin
        enc_inst    = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
        enc_imm_err = imm[0] | (imm[31:20] != {12{imm[31]}});
      end
      5'b10000: begin
        enc_inst    = {imm[31:12], base[11:0]};
        enc_imm_err = imm[11:0] != 12'h000;
      end
      5'b00000: begin
        enc_inst = base;
      end
      default: begin
        // Ambiguous select: pass base through untouched, report only the select error.
        enc_sel_err = 1'b1;
      end
    endcase
  end

  // Stage 1 registers.
  logic        s1_valid_q;
  logic [31:0] s1_inst_q;
  logic        s1_imm_err_q;
  logic        s1_sel_err_q;

  logic accept;
  logic s2_free;
  logic s1_drop;
  logic s1_move;

  assign s2_free   = !out_valid || out_ready;
  assign in_ready  = !s1_valid_q || s2_free;
  assign accept    = in_valid && in_ready;
  // In strict mode an erroneous word never needs S2 space: it is discarded from S1.
  assign s1_drop   = s1_valid_q && StrictMode && (s1_imm_err_q || s1_sel_err_q);
  assign s1_move   = s1_valid_q && !s1_drop && s2_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_inst_q    <= '0;
      s1_imm_err_q <= 1'b0;
      s1_sel_err_q <= 1'b0;
      out_valid    <= 1'b0;
      inst         <= '0;
      imm_err      <= 1'b0;
      sel_err      <= 1'b0;
      out_addr     <= '0;
      err_count    <= '0;
    end else begin
      if (accept) begin
        s1_valid_q   <= 1'b1;
        s1_inst_q    <= enc_inst;
        s1_imm_err_q <= enc_imm_err;
        s1_sel_err_q <= enc_sel_err;
      end else if (s1_move || s1_drop) begin
        s1_valid_q <= 1'b0;
      end

      if (s1_move) begin
        out_valid <= 1'b1;
        inst      <= s1_inst_q;
        imm_err   <= s1_imm_err_q;
        sel_err   <= s1_sel_err_q;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // Clear beats a coincident handshake increment.
      if (addr_clr) begin
        out_addr <= '0;
      end else if (out_valid && out_ready) begin
        out_addr <= out_addr + ADDR_W'(1);
      end

      if (accept && (enc_imm_err || enc_sel_err) && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule
